// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen register-block host arbiter.
// Holds the arbiter state enum, response status codes and a one-hot decoder.
package rggen_rtl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rggen_arbiter_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam int MAX_HOSTS = 8;

    // OR-reduction form keeps this a flat mux rather than a priority chain.
    function automatic logic [2:0] onehot_to_index(input logic [MAX_HOSTS-1:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_HOSTS; i++) begin
            if (onehot[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rggen_round_robin_selector.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping modulo N. Output is one-hot, or zero when nothing requests.
module rggen_round_robin_selector
    import rggen_rtl_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_request,
    input  logic [IW-1:0] i_pointer,
    output logic [N-1:0]  o_grant
);

    int w_best;

    // Distance from the pointer decides priority; the closest requester wins.
    always_comb begin
        w_best  = N;
        o_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (i_request[i] && (((i + N - int'(i_pointer)) % N) < w_best)) begin
                w_best = (i + N - int'(i_pointer)) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i_request[i] && (((i + N - int'(i_pointer)) % N) == w_best)) begin
                o_grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rggen_host_arbiter.sv
// Shares one register block's command bus between several host interfaces.
// Registered round-robin grant, held until the fabric returns response_ready.
module rggen_host_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS               = 2,
    parameter int DATA_WIDTH          = 32,
    parameter int LOCAL_ADDRESS_WIDTH = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [HOSTS-1:0]                          i_command_valid,
    input  logic [HOSTS-1:0]                          i_write,
    input  logic [HOSTS-1:0]                          i_read,
    input  logic [HOSTS-1:0][LOCAL_ADDRESS_WIDTH-1:0] i_address,
    input  logic [HOSTS-1:0][DATA_WIDTH/8-1:0]        i_strobe,
    input  logic [HOSTS-1:0][DATA_WIDTH-1:0]          i_write_data,
    input  logic [HOSTS-1:0][DATA_WIDTH-1:0]          i_write_mask,
    output logic [HOSTS-1:0]                          o_response_ready,
    output logic [DATA_WIDTH-1:0]                     o_read_data,
    output logic [1:0]                                o_status,
    output logic                                      o_command_valid,
    output logic                                      o_write,
    output logic                                      o_read,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]            o_address,
    output logic [DATA_WIDTH/8-1:0]                   o_strobe,
    output logic [DATA_WIDTH-1:0]                     o_write_data,
    output logic [DATA_WIDTH-1:0]                     o_write_mask,
    input  logic                                      i_response_ready,
    input  logic [DATA_WIDTH-1:0]                     i_read_data,
    input  logic [1:0]                                i_status,
    output logic [HOSTS-1:0]                          o_grant
);

    localparam int IW = (HOSTS > 1) ? $clog2(HOSTS) : 1;

    rggen_arbiter_state_e r_state, w_state_next;
    logic [HOSTS-1:0]     r_grant, w_grant_next, w_pick;
    logic [IW-1:0]        r_pointer, w_pointer_next, w_grant_index;
    logic                 w_complete;

    rggen_round_robin_selector #(.N(HOSTS), .IW(IW)) u_selector (
        .i_request (i_command_valid),
        .i_pointer (r_pointer),
        .o_grant   (w_pick)
    );

    assign w_grant_index = IW'(onehot_to_index(MAX_HOSTS'(r_grant)));
    assign w_complete    = (r_state == BUSY) && i_response_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_pointer <= '0;
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_pointer <= w_pointer_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_pointer_next = r_pointer;
        case (r_state)
            IDLE: begin
                if (|i_command_valid) begin
                    w_state_next = BUSY;
                    w_grant_next = w_pick;
                end
            end
            BUSY: begin
                // Completion forces one IDLE cycle so the fabric sees distinct commands.
                if (i_response_ready) begin
                    w_state_next   = IDLE;
                    w_grant_next   = '0;
                    w_pointer_next = (w_grant_index == IW'(HOSTS - 1)) ? '0
                                                                        : w_grant_index + IW'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Grant is zero outside BUSY, so the AND-OR mux drives the fabric to 0 in IDLE.
    always_comb begin
        o_address    = '0;
        o_strobe     = '0;
        o_write_data = '0;
        o_write_mask = '0;
        for (int h = 0; h < HOSTS; h++) begin
            if (r_grant[h]) begin
                o_address    = o_address    | i_address[h];
                o_strobe     = o_strobe     | i_strobe[h];
                o_write_data = o_write_data | i_write_data[h];
                o_write_mask = o_write_mask | i_write_mask[h];
            end
        end
    end

    assign o_write          = |(i_write & r_grant);
    assign o_read           = |(i_read & r_grant);
    assign o_command_valid  = (r_state == BUSY);
    assign o_grant          = r_grant;
    assign o_response_ready = w_complete ? r_grant : '0;
    assign o_read_data      = w_complete ? i_read_data : '0;
    assign o_status         = w_complete ? i_status : 2'b00;

endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Self-checking bench for rggen_host_arbiter (HOSTS=2): table-driven single
// transactions, hand-written round-robin/reset/violation sequences, response scoreboard.
module tb_rggen_host_arbiter;

    logic              clk;
    logic              rst_n;
    logic [1:0]        cv, wr, rd;
    logic [1:0][7:0]   addr;
    logic [1:0][3:0]   strb;
    logic [1:0][31:0]  wdat, wmsk;
    logic [1:0]        o_rr;
    logic [31:0]       o_rdata;
    logic [1:0]        o_st;
    logic              o_cv, o_wr, o_rd;
    logic [7:0]        o_addr;
    logic [3:0]        o_strb;
    logic [31:0]       o_wdat, o_wmsk;
    logic              resp_rdy;
    logic [31:0]       rdata;
    logic [1:0]        status;
    logic [1:0]        o_gnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  rr;
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          h;
        logic        w;
        logic [7:0]  a;
        logic [3:0]  s;
        logic [31:0] wd;
        logic [31:0] wm;
        logic [31:0] rdd;
        logic [1:0]  st;
        int          lat;
    } vec_t;
    vec_t tbl[5];

    rggen_host_arbiter #(.HOSTS(2), .DATA_WIDTH(32), .LOCAL_ADDRESS_WIDTH(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_command_valid  (cv),
        .i_write          (wr),
        .i_read           (rd),
        .i_address        (addr),
        .i_strobe         (strb),
        .i_write_data     (wdat),
        .i_write_mask     (wmsk),
        .o_response_ready (o_rr),
        .o_read_data      (o_rdata),
        .o_status         (o_st),
        .o_command_valid  (o_cv),
        .o_write          (o_wr),
        .o_read           (o_rd),
        .o_address        (o_addr),
        .o_strobe         (o_strb),
        .o_write_data     (o_wdat),
        .o_write_mask     (o_wmsk),
        .i_response_ready (resp_rdy),
        .i_read_data      (rdata),
        .i_status         (status),
        .o_grant          (o_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard: every pulse must match the oldest expected entry;
    // outside pulses the broadcast data/status must be zero.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (o_rr != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 64'(o_rr), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_ready", 64'(o_rr), 64'(e.rr));
                    chk("resp_data", 64'(o_rdata), 64'(e.d));
                    chk("resp_status", 64'(o_st), 64'(e.s));
                end
            end else begin
                chk("idle_data_zero", {30'd0, o_st, o_rdata}, 64'd0);
            end
        end
    end

    task automatic load(input int h, input logic w, input logic [7:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input logic [31:0] wm);
        int o;
        o = 1 - h;
        wr[h] = w; rd[h] = !w; addr[h] = a; strb[h] = s; wdat[h] = wd; wmsk[h] = wm;
        if (!cv[o]) begin
            wr[o] = 1'($urandom); rd[o] = 1'($urandom); addr[o] = 8'($urandom);
            strb[o] = 4'($urandom); wdat[o] = $urandom; wmsk[o] = $urandom;
        end
    endtask

    // Acts as the register fabric for one transaction of host h; starts and ends at a negedge.
    task automatic serve(input int h, input int lat, input logic [31:0] rdd, input logic [1:0] st,
                         input bit keep, input bit drop, input logic [1:0] arm, output int waited);
        int n;
        logic [1:0] oh;
        n  = 0;
        oh = 2'b01 << h;
        @(negedge clk);
        while (!o_cv && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        waited = n;
        chk("cmd_timeout", 64'(n < 20), 64'd1);
        chk("grant", 64'(o_gnt), 64'(oh));
        chk("fwd_write", 64'(o_wr), 64'(wr[h]));
        chk("fwd_read", 64'(o_rd), 64'(rd[h]));
        chk("fwd_addr", 64'(o_addr), 64'(addr[h]));
        chk("fwd_strobe", 64'(o_strb), 64'(strb[h]));
        chk("fwd_wdata", 64'(o_wdat), 64'(wdat[h]));
        chk("fwd_wmask", 64'(o_wmsk), 64'(wmsk[h]));
        if (drop) cv[h] = 1'b0;
        for (int k = 1; k < lat; k++) begin
            tick();
            @(negedge clk);
            chk("cmd_held", 64'(o_cv), 64'd1);
            chk("no_early_resp", 64'(o_rr), 64'd0);
        end
        tick();
        resp_rdy = 1'b1; rdata = rdd; status = st;
        cv = cv | arm;
        sb.push_back('{rr: oh, d: rdd, s: st});
        @(negedge clk);
        tick();
        resp_rdy = 1'b0; rdata = $urandom; status = 2'b11;
        if (!keep) cv[h] = 1'b0;
        @(negedge clk);
        chk("idle_gap", 64'(o_cv), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int w;
        tbl[0] = '{h: 0, w: 1'b0, a: 8'h04, s: 4'hF, wd: 32'h0,         wm: 32'h0,         rdd: 32'hCAFE_0001, st: 2'b00, lat: 2};
        tbl[1] = '{h: 1, w: 1'b1, a: 8'h08, s: 4'h3, wd: 32'h1234_5678, wm: 32'hFFFF_0000, rdd: 32'h0,         st: 2'b00, lat: 1};
        tbl[2] = '{h: 0, w: 1'b1, a: 8'h10, s: 4'hC, wd: 32'hA5A5_5A5A, wm: 32'h0000_FFFF, rdd: 32'hDEAD_BEEF, st: 2'b01, lat: 3};
        tbl[3] = '{h: 1, w: 1'b0, a: 8'hFC, s: 4'hF, wd: 32'h0,         wm: 32'h0,         rdd: 32'h8765_4321, st: 2'b10, lat: 2};
        tbl[4] = '{h: 0, w: 1'b0, a: 8'h00, s: 4'h1, wd: 32'h0,         wm: 32'h0,         rdd: 32'h0123_4567, st: 2'b00, lat: 1};

        rst_n = 1'b0; resp_rdy = 1'b0; rdata = '0; status = '0;
        cv = 2'b11; wr = 2'b11; rd = 2'b11; addr = '1; strb = '1; wdat = '1; wmsk = '1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 64'(o_cv), 64'd0);
        chk("rst_grant", 64'(o_gnt), 64'd0);
        chk("rst_resp", 64'(o_rr), 64'd0);
        chk("rst_fabric", {o_wr, o_rd, o_addr, o_strb, o_wdat[15:0], o_wmsk[15:0]}, 64'd0);
        cv = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);

        // Single transactions from idle; the other host carries garbage fields.
        for (int i = 0; i < 5; i++) begin
            load(tbl[i].h, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].wd, tbl[i].wm);
            cv[tbl[i].h] = 1'b1;
            chk("pre_cmd_low", 64'(o_cv), 64'd0);
            serve(tbl[i].h, tbl[i].lat, tbl[i].rdd, tbl[i].st, 1'b0, 1'b0, 2'b00, w);
            chk("latency1", 64'(w), 64'd0);
        end

        // Simultaneous pair from reset: 0 then 1, and again 0 then 1 after wrap.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            load(0, 1'b0, 8'h20 + 8'(r), 4'hF, 32'h0, 32'h0);
            load(1, 1'b1, 8'h40 + 8'(r), 4'h5, 32'h5555_0000 + 32'(r), 32'h00FF_00FF);
            cv = 2'b11;
            serve(0, 2, 32'h1000_0000 + 32'(r), 2'b00, 1'b0, 1'b0, 2'b00, w);
            serve(1, 1, 32'h2000_0000 + 32'(r), 2'b01, 1'b0, 1'b0, 2'b00, w);
        end

        // Host1 requests continuously while host0 issues four writes: strict alternation.
        load(1, 1'b1, 8'h80, 4'hF, 32'hBBBB_1111, 32'hFFFF_FFFF);
        cv[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load(0, 1'b1, 8'h04 * 8'(k), 4'hF, 32'hA000_0000 + 32'(k), 32'h0F0F_0000 + 32'(k));
            cv[0] = 1'b1;
            serve(0, 1 + k % 2, 32'h0, 2'b00, 1'b0, 1'b0, 2'b00, w);
            serve(1, 2, 32'hB000_0000 + 32'(k), 2'b00, (k < 3), 1'b0, 2'b00, w);
        end

        // Host1 request arrives in host0's completion cycle.
        load(0, 1'b0, 8'h30, 4'hF, 32'h0, 32'h0);
        cv[0] = 1'b1;
        serve(0, 2, 32'hC0C0_0000, 2'b00, 1'b0, 1'b0, 2'b10, w);
        load(1, 1'b0, 8'h34, 4'hF, 32'h0, 32'h0);
        serve(1, 1, 32'hC1C1_0000, 2'b00, 1'b0, 1'b0, 2'b00, w);

        // Reset during BUSY; pointer is 1 beforehand, so host0 winning afterwards shows it reset to 0.
        load(0, 1'b0, 8'h50, 4'hF, 32'h0, 32'h0);
        cv = 2'b01;
        serve(0, 1, 32'h5050_5050, 2'b00, 1'b0, 1'b0, 2'b00, w);
        load(1, 1'b1, 8'h54, 4'h3, 32'h5454_5454, 32'hFFFF_FFFF);
        cv = 2'b10;
        tick();
        @(negedge clk);
        chk("pre_rst_busy", {62'd0, o_cv, o_gnt[1]}, 64'd3);
        rst_n = 1'b0;
        resp_rdy = 1'b1; rdata = 32'hFEED_FACE; status = 2'b01;
        #1;
        chk("async_rst_cmd", 64'(o_cv), 64'd0);
        chk("async_rst_grant", 64'(o_gnt), 64'd0);
        chk("async_rst_resp", {o_rr, o_st, o_rdata}, 64'd0);
        chk("async_rst_fabric", {o_wr, o_rd, o_addr, o_strb, o_wdat[15:0], o_wmsk[15:0]}, 64'd0);
        load(0, 1'b0, 8'h58, 4'hF, 32'h0, 32'h0);
        cv = 2'b11;
        @(negedge clk);
        resp_rdy = 1'b0; status = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        serve(0, 2, 32'h5858_0000, 2'b00, 1'b0, 1'b0, 2'b00, w);
        serve(1, 1, 32'h5454_0000, 2'b00, 1'b0, 1'b0, 2'b00, w);

        // Granted host drops its request mid-transaction; SLVERR passes through.
        load(0, 1'b0, 8'h60, 4'hF, 32'h0, 32'h0);
        cv = 2'b01;
        serve(0, 3, 32'h0BAD_0BAD, 2'b10, 1'b0, 1'b1, 2'b00, w);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("final_idle", 64'(o_cv), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
